// File: rtl/nios_pio_datos_in_if.sv
// Avalon-MM slave bus bundle for the input PIO: word-addressed register
// access with active-low strobes, registered read data and interrupt.
interface nios_pio_datos_in_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/nios_pio_datos_in.sv
// Avalon-MM input PIO: synchronised data port, W1C edge capture and maskable irq.
// Optional per-bit input debouncing is enabled by defining PIO_DEBOUNCE_EN.
module nios_pio_datos_in #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned IRQ_MODE        = 0,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    nios_pio_datos_in_if.slave   avs,
    input  logic [WIDTH-1:0]     in_port
);

    if (WIDTH < 1 || WIDTH > 32 || EDGE_TYPE > 2 || IRQ_MODE > 1 ||
        SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
        $error("nios_pio_datos_in: parameter out of range");
    end

    localparam int unsigned PRIME_MAX = SYNC_STAGES + 1;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] rise, fall, det, clr;
    logic [2:0]       prime_q, prime_d;
    logic             primed;
    logic [31:0]      readdata_q, readdata_d, rd_mux;
    logic             irq_q, irq_d;
    logic             rd, wr;

    always_comb begin
        sync_d[0] = in_port;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [7:0]       dbc_q [WIDTH];
    logic [7:0]       dbc_d [WIDTH];

    // A bit's counter only runs while the synced input disagrees with filt;
    // any agreement restarts it, so only a stable change propagates.
    always_comb begin
        filt_d = filt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            dbc_d[i] = '0;
            if (in_sync[i] != filt_q[i]) begin
                if (dbc_q[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
                    filt_d[i] = in_sync[i];
                end else begin
                    dbc_d[i] = dbc_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) dbc_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int unsigned i = 0; i < WIDTH; i++) dbc_q[i] <= dbc_d[i];
        end
    end

    assign filt = filt_q;
`else
    assign filt = in_sync;
`endif

    assign rd     = avs.chipselect & ~avs.read_n;
    assign wr     = avs.chipselect & ~avs.write_n;
    assign primed = (prime_q == 3'(PRIME_MAX));

    always_comb begin
        rise = filt & ~prev_q;
        fall = ~filt & prev_q;
        case (EDGE_TYPE)
            1:       det = fall;
            2:       det = rise | fall;
            default: det = rise;
        endcase
    end

    always_comb begin
        prev_d    = filt;
        prime_d   = primed ? prime_q : prime_q + 3'd1;
        irqmask_d = irqmask_q;
        clr       = '0;
        if (wr && avs.address == 3'd2) irqmask_d = avs.writedata[WIDTH-1:0];
        if (wr && avs.address == 3'd3) clr = avs.writedata[WIDTH-1:0];
        // Set term is OR'd after the clear so a same-cycle edge survives a W1C.
        edge_cap_d = (edge_cap_q & ~clr) | (det & {WIDTH{primed}});
    end

    always_comb begin
        rd_mux = '0;
        case (avs.address)
            3'd0:    rd_mux = 32'(filt);
            3'd2:    rd_mux = 32'(irqmask_q);
            3'd3:    rd_mux = 32'(edge_cap_q);
            default: rd_mux = '0;
        endcase
        readdata_d = rd ? rd_mux : '0;
        if (IRQ_MODE == 1) irq_d = |(filt & irqmask_q);
        else               irq_d = |(edge_cap_q & irqmask_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q     <= '0;
            prime_q    <= '0;
            irqmask_q  <= '0;
            edge_cap_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            prev_q     <= prev_d;
            prime_q    <= prime_d;
            irqmask_q  <= irqmask_d;
            edge_cap_q <= edge_cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign avs.readdata = readdata_q;
    assign avs.irq      = irq_q;

endmodule
